// File: rtl/sayeh_alu_seq.sv
`default_nettype none
//==============================================================================
// Module      : sayeh_alu_seq
// Description : Sequential ALU for the Sayeh datapath. Accepts one operation
//               per start pulse. Logic/add/shift/compare ops complete in one
//               cycle; the 8x8 MUL runs a shift-add loop over MUL_STEPS
//               cycles. On completion it presents result/carry/zero with a
//               one-cycle done, a status-register load strobe (sr_load) and a
//               register-file write enable (res_we).
// Ports       : clk, rst            - clock, synchronous active-high reset
//               start, opcode       - launch request and operation select
//               a, b, cin           - operands and incoming C flag
//               busy                - high while MUL iterates (start ignored)
//               done                - one-cycle completion pulse
//               result, carry, zero - op result and flags, held between dones
//               sr_load, res_we     - status-register load / regfile write
// Revision    : 1.0 - initial release
//==============================================================================
module sayeh_alu_seq #(
    parameter int WIDTH     = 16,
    parameter int MUL_STEPS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             sr_load,
    output logic             res_we
);

    localparam int c_HALF  = WIDTH / 2;
    localparam int c_CNT_W = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_STEP = c_CNT_W'(MUL_STEPS - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_MUL  = 2'd1;
    localparam logic [1:0] c_ST_FIN  = 2'd2;

    localparam logic [3:0] c_OP_ADD = 4'd0;
    localparam logic [3:0] c_OP_SUB = 4'd1;
    localparam logic [3:0] c_OP_AND = 4'd2;
    localparam logic [3:0] c_OP_OR  = 4'd3;
    localparam logic [3:0] c_OP_XOR = 4'd4;
    localparam logic [3:0] c_OP_NOT = 4'd5;
    localparam logic [3:0] c_OP_SHL = 4'd6;
    localparam logic [3:0] c_OP_SHR = 4'd7;
    localparam logic [3:0] c_OP_CMP = 4'd8;
    localparam logic [3:0] c_OP_MUL = 4'd9;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_mcand;
    logic [c_HALF-1:0]  r_mplier;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_result;
    logic               r_carry;
    logic               r_zero;
    logic               r_sr_en;
    logic               r_we_en;

    logic               w_ready;
    logic               w_accept;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH-1:0]   w_res;
    logic               w_c;
    logic               w_z;
    logic               w_z_from_res;
    logic               w_sr;
    logic               w_we;
    logic [WIDTH-1:0]   w_pp;
    logic [WIDTH-1:0]   w_acc_next;

    // FIN doubles as a ready state so a new op can launch back-to-back.
    assign w_ready  = (r_state == c_ST_IDLE) || (r_state == c_ST_FIN);
    assign w_accept = start && w_ready;

    // Extra top bit carries the carry-out (ADD) or borrow (SUB).
    assign w_sum  = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
    assign w_diff = {1'b0, a} - {1'b0, b} - (WIDTH+1)'(cin);

    // Single-cycle op results, evaluated on the accept edge so later input
    // changes cannot disturb the committed value.
    always_comb begin
        w_res        = '0;
        w_c          = r_carry;
        w_z          = r_zero;
        w_z_from_res = 1'b1;
        w_sr         = 1'b1;
        w_we         = 1'b1;
        case (opcode)
            c_OP_ADD: begin w_res = w_sum[WIDTH-1:0];  w_c = w_sum[WIDTH];  end
            c_OP_SUB: begin w_res = w_diff[WIDTH-1:0]; w_c = w_diff[WIDTH]; end
            c_OP_AND: begin w_res = a & b; w_c = cin; end
            c_OP_OR:  begin w_res = a | b; w_c = cin; end
            c_OP_XOR: begin w_res = a ^ b; w_c = cin; end
            c_OP_NOT: begin w_res = ~a;    w_c = cin; end
            c_OP_SHL: begin w_res = {a[WIDTH-2:0], 1'b0}; w_c = a[WIDTH-1]; end
            c_OP_SHR: begin w_res = {1'b0, a[WIDTH-1:1]}; w_c = a[0];       end
            c_OP_CMP: begin
                // Result shows a but is never written back; flags compare a/b.
                w_res        = a;
                w_c          = (a < b);
                w_z          = (a == b);
                w_z_from_res = 1'b0;
                w_we         = 1'b0;
            end
            default: begin
                // Illegal opcode: result cleared, flags untouched, no strobes.
                w_z_from_res = 1'b0;
                w_sr         = 1'b0;
                w_we         = 1'b0;
            end
        endcase
        if (w_z_from_res) begin
            w_z = (w_res == '0);
        end
    end

    // One partial product per cycle: multiplicand shifts left, multiplier
    // shifts right, LSB of the multiplier gates the add.
    assign w_pp       = r_mplier[0] ? r_mcand : '0;
    assign w_acc_next = r_acc + w_pp;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_zero   <= 1'b0;
            r_sr_en  <= 1'b0;
            r_we_en  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE, c_ST_FIN: begin
                    if (w_accept) begin
                        if (opcode == c_OP_MUL) begin
                            r_state  <= c_ST_MUL;
                            r_cnt    <= '0;
                            r_mcand  <= {{(WIDTH-c_HALF){1'b0}}, a[c_HALF-1:0]};
                            r_mplier <= b[c_HALF-1:0];
                            r_acc    <= '0;
                        end else begin
                            r_state  <= c_ST_FIN;
                            r_result <= w_res;
                            r_carry  <= w_c;
                            r_zero   <= w_z;
                            r_sr_en  <= w_sr;
                            r_we_en  <= w_we;
                        end
                    end else begin
                        r_state <= c_ST_IDLE;
                    end
                end
                c_ST_MUL: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= {r_mcand[WIDTH-2:0], 1'b0};
                    r_mplier <= {1'b0, r_mplier[c_HALF-1:1]};
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST_STEP) begin
                        r_state  <= c_ST_FIN;
                        r_cnt    <= '0;
                        r_result <= w_acc_next;
                        r_carry  <= 1'b0;
                        r_zero   <= (w_acc_next == '0);
                        r_sr_en  <= 1'b1;
                        r_we_en  <= 1'b1;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign busy    = (r_state == c_ST_MUL);
    assign done    = (r_state == c_ST_FIN);
    assign sr_load = done && r_sr_en;
    assign res_we  = done && r_we_en;
    assign result  = r_result;
    assign carry   = r_carry;
    assign zero    = r_zero;

endmodule
`default_nettype wire
